// File: rtl/i2s_dac_out.sv
// I2S transmitter for the two-voice synth: mixes or routes the voices, converts them to
// two's-complement and serialises 32-slot frames (left then right, MSB first, one-BCLK delay).
module i2s_dac_out #(
    parameter int unsigned BCLK_DIV = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [15:0] i_osc1,
    input  logic [15:0] i_osc2,
    input  logic        i_stereo,
    input  logic        i_mute,
    output logic        o_bclk,
    output logic        o_lrclk,
    output logic        o_sdata,
    output logic        o_sample_strobe
);

    localparam int unsigned      DIV_W     = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [4:0]       SLOT_LAST = 5'd31;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    state_e           state_q,      state_d;
    logic [DIV_W-1:0] div_q,        div_d;
    logic [4:0]       slot_q,       slot_d;
    logic [31:0]      frame_word_q, frame_word_d;
    logic             last_bit_q,   last_bit_d;
    logic             bclk_q,       bclk_d;
    logic             lrclk_q,      lrclk_d;
    logic             sdata_q,      sdata_d;
    logic             strobe_q,     strobe_d;

    logic [15:0] mono;
    logic [15:0] left_pcm;
    logic [15:0] right_pcm;

    // Offset-binary to two's-complement: midscale 0x8000 becomes zero.
    function automatic logic [15:0] to_twos(input logic [15:0] x);
        return {~x[15], x[14:0]};
    endfunction

    always_comb begin
        mono = 16'((17'(i_osc1) + 17'(i_osc2)) >> 1);
        if (i_mute) begin
            left_pcm  = '0;
            right_pcm = '0;
        end else if (i_stereo) begin
            left_pcm  = to_twos(i_osc1);
            right_pcm = to_twos(i_osc2);
        end else begin
            left_pcm  = to_twos(mono);
            right_pcm = to_twos(mono);
        end
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch below can leave one unassigned and infer a latch.
        state_d      = state_q;
        div_d        = div_q;
        slot_d       = slot_q;
        frame_word_d = frame_word_q;
        last_bit_d   = last_bit_q;
        bclk_d       = bclk_q;
        lrclk_d      = lrclk_q;
        sdata_d      = sdata_q;
        strobe_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end
            end

            ST_RUN: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!bclk_q) begin
                        bclk_d = 1'b1;
                    end else if (slot_q != SLOT_LAST) begin
                        // Falling edge inside a frame: slot s carries frame_word[32-s].
                        bclk_d  = 1'b0;
                        slot_d  = slot_q + 5'd1;
                        lrclk_d = (slot_q >= 5'd15);
                        sdata_d = frame_word_q[5'd31 - slot_q];
                        if (slot_q == 5'd30) begin
                            last_bit_d = frame_word_q[0];
                        end
                    end else if (i_en) begin
                        // Frame start: slot 0 finishes the previous right word while the new pair is latched.
                        bclk_d       = 1'b0;
                        slot_d       = '0;
                        lrclk_d      = 1'b0;
                        sdata_d      = last_bit_q;
                        frame_word_d = {left_pcm, right_pcm};
                        strobe_d     = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        bclk_d     = 1'b0;
                        lrclk_d    = 1'b1;
                        sdata_d    = 1'b0;
                        slot_d     = SLOT_LAST;
                        last_bit_d = 1'b0;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            slot_q       <= SLOT_LAST;
            frame_word_q <= '0;
            last_bit_q   <= 1'b0;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b1;
            sdata_q      <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q      <= state_d;
            div_q        <= div_d;
            slot_q       <= slot_d;
            frame_word_q <= frame_word_d;
            last_bit_q   <= last_bit_d;
            bclk_q       <= bclk_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            strobe_q     <= strobe_d;
        end
    end

    assign o_bclk          = bclk_q;
    assign o_lrclk         = lrclk_q;
    assign o_sdata         = sdata_q;
    assign o_sample_strobe = strobe_q;

endmodule

// File: tb/tb_i2s_dac_out.sv
// Directed bench for i2s_dac_out: a BCLK_DIV=8 instance decoded into a word scoreboard,
// plus a BCLK_DIV=2 instance for the fast-divider timing and bit-mapping sweep.
module tb_i2s_dac_out;

    localparam int SIG_BCLK8      = 0;
    localparam int SIG_STROBE8    = 1;
    localparam int SIG_STROBE2    = 2;
    localparam int SIG_BCLK2      = 3;
    localparam int SIG_BCLK8_FALL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] osc1;
    logic [15:0] osc2;
    logic        stereo;
    logic        mute;

    logic bclk8, lrclk8, sdata8, strobe8;
    logic bclk2, lrclk2, sdata2, strobe2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2s_dac_out #(.BCLK_DIV(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_osc1(osc1), .i_osc2(osc2),
        .i_stereo(stereo), .i_mute(mute), .o_bclk(bclk8), .o_lrclk(lrclk8),
        .o_sdata(sdata8), .o_sample_strobe(strobe8)
    );

    i2s_dac_out #(.BCLK_DIV(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_osc1(osc1), .i_osc2(osc2),
        .i_stereo(stereo), .i_mute(mute), .o_bclk(bclk2), .o_lrclk(lrclk2),
        .o_sdata(sdata2), .o_sample_strobe(strobe2)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: midscale subtraction instead of a bit flip, mono as an integer average.
    function automatic logic [15:0] ref_pcm(input logic [15:0] u);
        int v;
        v = int'(u) - 32768;
        return v[15:0];
    endfunction

    function automatic logic [31:0] ref_word(input logic [15:0] a, input logic [15:0] b,
                                             input logic st, input logic mu);
        int avg;
        avg = (int'(a) + int'(b)) / 2;
        if (mu) return 32'h0;
        if (st) return {ref_pcm(a), ref_pcm(b)};
        return {ref_pcm(avg[15:0]), ref_pcm(avg[15:0])};
    endfunction

    // Scoreboard producer: expected words for the frame whose samples are latched now.
    logic [15:0] exp_q[$];
    int          cyc = 0;
    int          strobe_cyc = 0;
    int          prev_strobe_cyc = 0;
    int          n_strobes8 = 0;
    logic [31:0] push_word;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge strobe8) begin
        push_word = ref_word(osc1, osc2, stereo, mute);
        exp_q.push_back(push_word[31:16]);
        exp_q.push_back(push_word[15:0]);
        prev_strobe_cyc = strobe_cyc;
        strobe_cyc      = cyc;
        n_strobes8++;
    end

    // Scoreboard consumer: I2S decoder on the DIV=8 stream, aligned on LRCLK falling.
    int          mon_idx           = -1;
    logic        mon_prev_lr       = 1'b1;
    logic        mon_right_pending = 1'b0;
    logic        mon_lr_ok         = 1'b1;
    logic [15:0] mon_shift         = '0;
    logic [15:0] last_left         = 'x;
    logic [15:0] last_right        = 'x;
    logic        mon_lr, mon_sd;
    logic [15:0] mon_exp;

    task automatic pop_and_compare(input string tag, input logic [15:0] got);
        check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check(tag, {16'h0, got}, {16'h0, mon_exp});
        end
    endtask

    always @(posedge bclk8) begin
        mon_lr = lrclk8;
        mon_sd = sdata8;
        if (mon_prev_lr && !mon_lr) begin
            if (mon_right_pending) begin
                check("right_lrclk", mon_lr_ok, 1);
                last_right = {mon_shift[14:0], mon_sd};
                pop_and_compare("right_word", last_right);
            end else begin
                check("slot0_held_bit", mon_sd, 0);
            end
            mon_idx           = 0;
            mon_right_pending = 1'b0;
            mon_lr_ok         = 1'b1;
            mon_shift         = '0;
        end else if (mon_idx >= 0 && mon_idx < 32) begin
            mon_idx++;
            if (mon_lr !== (mon_idx >= 16)) mon_lr_ok = 1'b0;
            mon_shift = {mon_shift[14:0], mon_sd};
            if (mon_idx == 16) begin
                check("left_lrclk", mon_lr_ok, 1);
                last_left = mon_shift;
                pop_and_compare("left_word", last_left);
                mon_shift = '0;
                mon_lr_ok = 1'b1;
            end
            if (mon_idx == 31) mon_right_pending = 1'b1;
        end
        mon_prev_lr = mon_lr;
    end

    // A stopped or reset stream leaves exactly one unverifiable right word behind.
    task automatic flush_stream(input string tag);
        check(tag, exp_q.size(), 1);
        exp_q.delete();
        mon_idx           = -1;
        mon_prev_lr       = 1'b1;
        mon_right_pending = 1'b0;
        mon_lr_ok         = 1'b1;
    endtask

    function automatic logic sig_now(input int which);
        case (which)
            SIG_BCLK8:      return bclk8;
            SIG_STROBE8:    return strobe8;
            SIG_STROBE2:    return strobe2;
            SIG_BCLK2:      return bclk2;
            SIG_BCLK8_FALL: return ~bclk8;
            default:        return 1'b0;
        endcase
    endfunction

    // Cycles until the selected signal rises, sampled 1 ns after each edge; -1 on timeout.
    task automatic wait_rise(input int which, input int limit, output int n);
        logic prev, cur;
        prev = sig_now(which);
        n    = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            cur = sig_now(which);
            if (cur && !prev) begin
                n = i;
                break;
            end
            prev = cur;
        end
    endtask

    task automatic wait_idx(input int k, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (mon_idx == k) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, found, 1);
    endtask

    task automatic next_strobe8(input string tag);
        int n;
        wait_rise(SIG_STROBE8, 1200, n);
        check(tag, n > 0, 1);
    endtask

    // New inputs are latched at the next strobe; that frame's right word lands 8 cycles into the one after.
    task automatic settle(input string tag);
        next_strobe8({tag, "_latch"});
        next_strobe8({tag, "_next"});
        repeat (24) @(posedge clk);
        #1;
    endtask

    task automatic check_enable_timing(input string tag);
        int n1, n2;
        @(posedge clk);
        #1;
        wait_rise(SIG_BCLK8, 64, n1);
        check({tag, "_first_rise"}, n1, 8);
        check({tag, "_lrclk_pre"}, lrclk8, 1);
        wait_rise(SIG_STROBE8, 64, n2);
        check({tag, "_first_strobe"}, n1 + n2, 16);
        check({tag, "_lrclk_at_strobe"}, lrclk8, 0);
    endtask

    initial begin
        int          n, n2, hi, s0, timeouts, lr_bad;
        logic [31:0] word;
        logic        slot0_bit;

        rst_n = 1'b0; en = 1'b0; mute = 1'b0; stereo = 1'b1;
        osc1 = 16'h8000; osc2 = 16'hC000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bclk", bclk8, 0);
        check("rst_lrclk", lrclk8, 1);
        check("rst_sdata", sdata8, 0);
        check("rst_strobe", strobe8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_bclk", bclk8, 0);
        check("idle_lrclk", lrclk8, 1);

        // Enable timing, frame period, stereo words.
        en = 1'b1;
        check_enable_timing("start");
        wait_rise(SIG_STROBE8, 1200, n);
        check("period_1", n, 512);
        wait_rise(SIG_STROBE8, 1200, n);
        check("period_2", n, 512);
        repeat (24) @(posedge clk);
        #1;
        check("stereo_left", last_left, 16'h0000);
        check("stereo_right", last_right, 16'h4000);

        // Mono mix.
        stereo = 1'b0; osc1 = 16'hFFFF; osc2 = 16'h0000;
        settle("mono_full");
        check("mono_full_left", last_left, 16'hFFFF);
        check("mono_full_right", last_right, 16'hFFFF);
        osc1 = 16'h0001; osc2 = 16'h0001;
        settle("mono_low");
        check("mono_low_left", last_left, 16'h8001);
        check("mono_low_right", last_right, 16'h8001);

        // Mute, then a mid-frame input change must not reach the frame in flight.
        mute = 1'b1; osc1 = 16'h1234;
        settle("mute");
        check("mute_left", last_left, 16'h0000);
        check("mute_right", last_right, 16'h0000);
        mute = 1'b0; stereo = 1'b1; osc1 = 16'h1234; osc2 = 16'h5678;
        next_strobe8("capture_latch");
        wait_idx(5, "capture_slot5");
        osc1 = 16'hEEEE;
        next_strobe8("capture_next");
        repeat (24) @(posedge clk);
        #1;
        check("capture_left", last_left, 16'h9234);
        check("capture_right", last_right, 16'hD678);

        // A stop request withdrawn before slot 31 ends leaves the stream continuous.
        wait_idx(10, "cancel_slot10");
        en = 1'b0;
        wait_idx(20, "cancel_slot20");
        en = 1'b1;
        next_strobe8("cancel_strobe");
        check("cancel_period", strobe_cyc - prev_strobe_cyc, 512);

        // Stop mid-frame: frame completes, then everything parks at idle values.
        osc1 = 16'h1234; osc2 = 16'hC003;
        settle("stop_prep");
        wait_idx(5, "stop_slot5");
        en = 1'b0;
        wait_idx(31, "stop_slot31");
        check("stop_slot31_sdata", sdata8, 1);
        wait_rise(SIG_BCLK8_FALL, 32, n);
        check("stop_fall_delay", n, 8);
        check("stop_bclk", bclk8, 0);
        check("stop_lrclk", lrclk8, 1);
        check("stop_sdata", sdata8, 0);
        check("stop_strobe", strobe8, 0);
        s0 = n_strobes8;
        hi = 0;
        repeat (600) begin
            @(posedge clk);
            #1;
            if (bclk8 !== 1'b0) hi++;
        end
        check("stop_bclk_parked", hi, 0);
        check("stop_no_strobe", n_strobes8 - s0, 0);
        flush_stream("stop_sb_pending");
        en = 1'b1;
        check_enable_timing("restart");
        settle("restart_words");
        check("restart_left", last_left, 16'h9234);
        check("restart_right", last_right, 16'h4003);

        // Asynchronous reset at slot 20 while BCLK and SDATA are both high.
        osc2 = 16'h9FFF;
        settle("areset_prep");
        wait_idx(20, "areset_slot20");
        check("areset_pre_bclk", bclk8, 1);
        check("areset_pre_sdata", sdata8, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("areset_bclk", bclk8, 0);
        check("areset_lrclk", lrclk8, 1);
        check("areset_sdata", sdata8, 0);
        check("areset_strobe", strobe8, 0);
        flush_stream("areset_sb_pending");
        en = 1'b0;
        osc1 = 16'h1234; osc2 = 16'hABCD; stereo = 1'b1; mute = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // BCLK_DIV=2: same structure, 128-cycle frames.
        @(posedge clk);
        #1;
        en = 1'b1;
        @(posedge clk);
        #1;
        wait_rise(SIG_BCLK2, 16, n);
        check("div2_first_rise", n, 2);
        wait_rise(SIG_STROBE2, 16, n2);
        check("div2_first_strobe", n + n2, 4);
        wait_rise(SIG_STROBE2, 300, n);
        check("div2_period", n, 128);
        word = '0; timeouts = 0; lr_bad = 0; slot0_bit = 1'bx;
        for (int s = 0; s <= 32; s++) begin
            wait_rise(SIG_BCLK2, 8, n);
            if (n < 0) timeouts++;
            if (s == 0) slot0_bit = sdata2;
            else word = {word[30:0], sdata2};
            if (lrclk2 !== ((s >= 16 && s <= 31) ? 1'b1 : 1'b0)) lr_bad++;
        end
        check("div2_timeouts", timeouts, 0);
        check("div2_lrclk", lr_bad, 0);
        check("div2_slot0_prev_lsb", slot0_bit, 1);
        check("div2_word", word, ref_word(16'h1234, 16'hABCD, 1'b1, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded 2 ms, observed no finish, expected finish");
        $fatal(1, "watchdog timeout");
    end

endmodule

// File: doc/i2s_dac_out.md
Name: i2s_dac_out

Overview:
- Output stage after the per-voice amp outputs.
- Takes the two unsigned 16-bit voice samples and mixes them to mono, or routes them as stereo.
- Converts the result to two's-complement and serialises it as a standard I2S stream (BCLK/LRCLK/SDATA) for an external audio DAC.
- Paces the voices with a once-per-frame sample strobe.

Parameters:
- BCLK_DIV, 8: i_clk cycles per BCLK half-period; legal values ≥2. Default at 50 MHz gives BCLK 3.125 MHz and frame rate 97.66 kHz.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  run enable; stream starts/stops on frame boundaries only
- i_osc1  in  16  voice 1 sample, unsigned offset-binary
- i_osc2  in  16  voice 2 sample, unsigned offset-binary
- i_stereo  in  1  1: left=osc1, right=osc2; 0: both channels carry the mono mix
- i_mute  in  1  1: both channels transmit 0x0000
- o_bclk  out  1  I2S bit clock
- o_lrclk  out  1  I2S word select; 0 = left, 1 = right
- o_sdata  out  1  I2S serial data, MSB first
- o_sample_strobe  out  1  one i_clk pulse when a new frame's samples are latched

Behaviour:
- Reset values (asynchronous, i_rst_n=0):
  - o_bclk=0, o_lrclk=1, o_sdata=0, o_sample_strobe=0
  - state=IDLE, divider=0, slot=31
  - frame word=0, held last bit=0
- States:
  - IDLE: outputs frozen at reset values. Moves to RUN on the cycle i_en=1 is sampled; divider restarts at 0.
  - RUN: divider counts 0..BCLK_DIV-1. On terminal count o_bclk toggles and the divider wraps. BCLK half-periods are exactly BCLK_DIV cycles; first toggle after entry is a rising edge.
  - Each BCLK falling edge advances slot (31 wraps to 0). All o_lrclk/o_sdata changes happen in the same i_clk cycle that o_bclk goes 0.
- Slot mapping (32 slots per frame):
  - o_lrclk=0 for slots 0..15, 1 for slots 16..31.
  - o_sdata in slot s = frame_word[31-(s-1)] for s=1..31.
  - Slot 0 carries bit 0 of the previous frame word, i.e. the standard one-BCLK I2S delay. On the first frame after reset it is 0.
- Frame start (falling edge entering slot 0):
  - Sample i_osc1, i_osc2, i_stereo and i_mute.
  - Load frame_word = {left, right}.
  - Pulse o_sample_strobe high for exactly one i_clk cycle.
  - Inputs are ignored at every other time.
- Arithmetic:
  - s(x) = {~x[15], x[14:0]} (offset-binary to two's-complement).
  - mono = s( (i_osc1 + i_osc2) >> 1 ), with the sum computed at 17 bits and truncated toward zero. No overflow possible.
  - stereo: left = s(i_osc1), right = s(i_osc2).
  - mute overrides both channels to 0x0000.
- Stop:
  - i_en=0 mid-frame: the current frame completes through slot 31's high phase.
  - At the falling edge that would enter slot 0, return to IDLE: o_bclk=0, o_lrclk=1, o_sdata=0, no strobe, held last bit cleared.
  - i_en re-asserted before that edge: the stop is cancelled and the stream is continuous.
- Timing:
  - Frame period = 64*BCLK_DIV i_clk cycles exactly.
  - Latency from a sample latch to that sample's MSB on o_sdata = one BCLK period (2*BCLK_DIV cycles) after the strobe.
- Asynchronous reset mid-frame aborts immediately to reset values. There is no partial-frame completion.

Test Plan:
1. Reset then i_en=1, BCLK_DIV=8 → first o_bclk rise at 8 cycles, first strobe at 16 cycles with o_lrclk 1→0; strobes every 512 cycles thereafter.
2. Stereo, osc1=0x8000, osc2=0xC000 → left word 0x0000 and right word 0x4000 decoded from o_sdata on BCLK rising edges; each MSB appears one slot after the LRCLK edge.
3. Mono, osc1=0xFFFF, osc2=0x0000 → both words 0xFFFF. Then osc1=osc2=0x0001 → both words 0x8001.
4. i_mute=1 with osc1=0x1234 → both words 0x0000. Changing i_osc1 mid-frame does not alter the frame in flight (value captured only at strobe).
5. Drop i_en at slot 5 → frame completes, bclk stops low, lrclk high, sdata 0, no further strobe. Re-assert i_en → restart timing as in scenario 1.
6. Assert i_rst_n=0 at slot 20 → all outputs reach reset values without waiting for an i_clk edge. Then sweep BCLK_DIV=2 → frame period 128 cycles, same bit mapping.
